// File: rtl/frog_pkg.sv
// Shared definitions for the frog input conditioner: per-button FSM encoding,
// button bit positions and a constant helper for counter sizing.
package frog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } btn_state_e;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchronizer, debounce FSM and auto-repeat timer.
// move_ev is a combinational one-cycle event; the top level arbitrates and registers it.
module btn_debounce_fsm
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic held,
  output logic move_ev
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       sync_q;
  logic             pressed;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_periodic_q, rep_periodic_d;

  always_ff @(posedge clk) begin
    // NOTE: reset parks the synchronizer at the released level (1), so a
    // button held through reset is seen as a fresh press afterwards.
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], btn_n};
  end

  assign pressed = ~sync_q[1];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= ST_IDLE;
      deb_cnt_q      <= '0;
      rep_cnt_q      <= '0;
      rep_periodic_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      deb_cnt_q      <= deb_cnt_d;
      rep_cnt_q      <= rep_cnt_d;
      rep_periodic_q <= rep_periodic_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d        = state_q;
    deb_cnt_d      = sat_inc(deb_cnt_q);
    rep_cnt_d      = rep_cnt_q;
    rep_periodic_d = rep_periodic_q;
    move_ev        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        deb_cnt_d = '0;
        if (pressed) state_d = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!pressed) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d        = ST_HELD;
          deb_cnt_d      = '0;
          rep_cnt_d      = '0;
          rep_periodic_d = 1'b0;
          move_ev        = 1'b1;
        end
      end
      ST_HELD: begin
        // Repeat timer only advances in HELD; a release bounce freezes it.
        deb_cnt_d = '0;
        rep_cnt_d = sat_inc(rep_cnt_q);
        if (REPEAT_EN != 0 && rep_cnt_q == (rep_periodic_q ? REP_LAST : HOLD_LAST)) begin
          move_ev        = 1'b1;
          rep_cnt_d      = '0;
          rep_periodic_d = 1'b1;
        end
        if (!pressed) state_d = ST_RELEASE_CHK;
      end
      ST_RELEASE_CHK: begin
        if (pressed) begin
          state_d   = ST_HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign held = (state_q == ST_HELD) || (state_q == ST_RELEASE_CHK);

endmodule

// File: rtl/frog_input_conditioner.sv
// Four debounced buttons with auto-repeat, per-axis arbitration
// (up beats down, right beats left) and registered one-cycle move pulses.
module frog_input_conditioner
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int REPEAT_EN       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_n,
  output logic                mv_up,
  output logic                mv_down,
  output logic                mv_left,
  output logic                mv_right,
  output logic [NUM_BTNS-1:0] held
);

  logic [NUM_BTNS-1:0] move_ev;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_n  (btn_n[i]),
      .held   (held[i]),
      .move_ev(move_ev[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mv_up    <= 1'b0;
      mv_down  <= 1'b0;
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
    end else begin
      mv_up    <= move_ev[BTN_UP];
      mv_down  <= move_ev[BTN_DOWN] & ~move_ev[BTN_UP];
      mv_right <= move_ev[BTN_RIGHT];
      mv_left  <= move_ev[BTN_LEFT] & ~move_ev[BTN_RIGHT];
    end
  end

endmodule

// File: tb/tb_frog_input_conditioner.sv
// Self-checking bench: directed press table, hand-written multi-cycle corners,
// and randomized traces compared against a run-length behavioural model.
module tb_frog_input_conditioner;

  localparam int D    = 4;
  localparam int H    = 10;
  localparam int R    = 5;
  localparam int MAXC = 256;

  logic       clk;
  logic       reset;
  logic [3:0] btn_n;
  logic       mv_up, mv_down, mv_left, mv_right;
  logic [3:0] held;

  frog_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .REPEAT_EN      (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .mv_up   (mv_up),
    .mv_down (mv_down),
    .mv_left (mv_left),
    .mv_right(mv_right),
    .held    (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus and observations indexed by post-reset edge number.
  logic [3:0] stim_btn [MAXC];
  logic       stim_rst [MAXC];
  logic [3:0] obs_mv   [MAXC];
  logic [3:0] obs_held [MAXC];
  logic [3:0] exp_mv   [MAXC];
  logic [3:0] exp_held [MAXC];

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [3:0] exp_pulse;
  } press_vec_t;

  press_vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      stim_btn[k] = 4'hF;
      stim_rst[k] = 1'b0;
    end
  endtask

  // Reset for 3 cycles, then drive stim arrays; edge 0 is the first edge with reset low.
  task automatic run_trace(input int len);
    reset = 1'b1;
    btn_n = stim_btn[0];
    repeat (3) @(negedge clk);
    check("reset_mv", {60'd0, mv_up, mv_down, mv_left, mv_right}, 64'd0);
    check("reset_held", {60'd0, held}, 64'd0);
    for (int k = 0; k < len; k++) begin
      reset = stim_rst[k];
      btn_n = stim_btn[k];
      @(negedge clk);
      obs_mv[k]   = {mv_up, mv_down, mv_left, mv_right};
      obs_held[k] = held;
    end
    reset = 1'b0;
  endtask

  // Behavioural model: a button's level flips after D+1 consecutive synchronized
  // samples disagreeing with it; repeats fall at H, H+R, H+2R... HELD cycles.
  task automatic run_model(input int len);
    bit lvl [4];
    int run [4];
    int hcnt [4];
    int rst_edge;
    logic [3:0] ev;
    bit s;
    rst_edge = -1;
    for (int b = 0; b < 4; b++) begin
      lvl[b] = 0; run[b] = 0; hcnt[b] = 0;
    end
    for (int k = 0; k < len; k++) begin
      ev = 4'b0;
      if (stim_rst[k]) begin
        for (int b = 0; b < 4; b++) begin
          lvl[b] = 0; run[b] = 0; hcnt[b] = 0;
        end
        rst_edge    = k;
        exp_mv[k]   = 4'b0;
        exp_held[k] = 4'b0;
        continue;
      end
      for (int b = 0; b < 4; b++) begin
        s = (k - 2 > rst_edge) ? !stim_btn[k-2][b] : 1'b0;
        if (lvl[b] && run[b] == 0) begin
          hcnt[b]++;
          if (hcnt[b] == H || (hcnt[b] > H && (hcnt[b] - H) % R == 0)) ev[b] = 1'b1;
        end
        if (s != lvl[b]) begin
          run[b]++;
          if (run[b] == D + 1) begin
            lvl[b] = s;
            run[b] = 0;
            if (s) begin
              ev[b]   = 1'b1;
              hcnt[b] = 0;
            end
          end
        end else begin
          run[b] = 0;
        end
      end
      exp_held[k] = {lvl[3], lvl[2], lvl[1], lvl[0]};
      exp_mv[k]   = {ev[3], ev[2] & ~ev[3], ev[1] & ~ev[0], ev[0]};
    end
  endtask

  function automatic logic [63:0] pulse_map(input int b, input int len);
    logic [63:0] m = '0;
    for (int c = 0; c < len && c < 64; c++) m[c] = obs_mv[c][b];
    return m;
  endfunction

  function automatic logic [63:0] held_map(input int b, input int len);
    logic [63:0] m = '0;
    for (int c = 0; c < len && c < 64; c++) m[c] = obs_held[c][b];
    return m;
  endfunction

  function automatic logic [63:0] map_of(input int cyc[$]);
    logic [63:0] m = '0;
    foreach (cyc[i]) m[cyc[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] range_map(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int c = lo; c <= hi; c++) m[c] = 1'b1;
    return m;
  endfunction

  task automatic gen_random(input int len);
    int   remaining;
    logic val;
    clear_stim();
    for (int b = 0; b < 4; b++) begin
      remaining = 0;
      val       = 1'b1;
      for (int k = 0; k < len; k++) begin
        if (remaining == 0) begin
          val       = ~val;
          remaining = int'($urandom_range(1, 24));
        end
        stim_btn[k][b] = val;
        remaining--;
      end
    end
    for (int k = 0; k < len; k++) stim_rst[k] = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          q[$];
    logic [63:0] others;
    reset = 1'b1;
    btn_n = 4'hF;

    vecs[0] = '{"up",         4'b1000, 4'b1000};
    vecs[1] = '{"right",      4'b0001, 4'b0001};
    vecs[2] = '{"up_down",    4'b1100, 4'b1000};
    vecs[3] = '{"left_right", 4'b0011, 4'b0001};
    vecs[4] = '{"up_left",    4'b1010, 4'b1010};
    vecs[5] = '{"all",        4'b1111, 4'b1001};
    vecs[6] = '{"down_left",  4'b0110, 4'b0110};

    // Buttons low on edges 10..17: press at 16, released level from 24.
    foreach (vecs[i]) begin
      clear_stim();
      for (int k = 10; k < 18; k++) stim_btn[k] = ~vecs[i].mask;
      run_trace(40);
      check({vecs[i].name, "_pulse16"}, {60'd0, obs_mv[16]}, {60'd0, vecs[i].exp_pulse});
      others = '0;
      for (int c = 0; c < 40; c++) if (c != 16) others[c] = |obs_mv[c];
      check({vecs[i].name, "_no_other_pulse"}, others, 64'd0);
      check({vecs[i].name, "_held15"}, {60'd0, obs_held[15]}, 64'd0);
      check({vecs[i].name, "_held16"}, {60'd0, obs_held[16]}, {60'd0, vecs[i].mask});
      check({vecs[i].name, "_held23"}, {60'd0, obs_held[23]}, {60'd0, vecs[i].mask});
      check({vecs[i].name, "_held24"}, {60'd0, obs_held[24]}, 64'd0);
    end

    // Bounce on right: 2 low / 2 high for 20 cycles never debounces.
    clear_stim();
    for (int k = 0; k < 20; k++) stim_btn[k][0] = ((k / 2) % 2 == 1);
    run_trace(50);
    check("bounce_right", pulse_map(0, 50), 64'd0);
    check("bounce_held", held_map(0, 50), 64'd0);

    // Auto-repeat on left held 40 cycles.
    clear_stim();
    for (int k = 0; k < 40; k++) stim_btn[k][1] = 1'b0;
    run_trace(60);
    q = {6, 16, 21, 26, 31, 36, 41};
    check("repeat_left", pulse_map(1, 60), map_of(q));
    check("repeat_held", held_map(1, 60), range_map(6, 45));
    check("repeat_others", pulse_map(3, 60) | pulse_map(2, 60) | pulse_map(0, 60), 64'd0);

    // Release bounce: two high cycles return to HELD, repeat timer paused, not cleared.
    clear_stim();
    for (int k = 0; k < 30; k++) stim_btn[k][3] = (k == 12 || k == 13);
    run_trace(30);
    q = {6, 18, 23, 28};
    check("rel_bounce_up", pulse_map(3, 30), map_of(q));
    check("rel_bounce_held", held_map(3, 30), range_map(6, 29));

    // Reset mid-debounce, button still low afterwards.
    clear_stim();
    for (int k = 0; k < 40; k++) stim_btn[k][0] = 1'b0;
    for (int k = 2; k < 5; k++) stim_rst[k] = 1'b1;
    run_trace(40);
    q = {11};
    check("rst_deb_right", pulse_map(0, 20), map_of(q));
    check("rst_deb_mv_in_reset", {60'd0, obs_mv[3]}, 64'd0);
    check("rst_deb_held_in_reset", {60'd0, obs_held[3]}, 64'd0);

    // Reset mid-repeat aborts the pending repeat at 16.
    clear_stim();
    for (int k = 0; k < 40; k++) stim_btn[k][2] = 1'b0;
    stim_rst[14] = 1'b1;
    stim_rst[15] = 1'b1;
    run_trace(40);
    q = {6, 22, 32, 37};
    check("rst_rep_down", pulse_map(2, 40), map_of(q));
    check("rst_rep_held", held_map(2, 40), range_map(6, 13) | range_map(22, 39));

    // Randomized traces against the behavioural model.
    for (int t = 0; t < 6; t++) begin
      gen_random(200);
      run_trace(200);
      run_model(200);
      for (int k = 0; k < 200; k++) begin
        check($sformatf("rand%0d_mv_c%0d", t, k), {60'd0, obs_mv[k]}, {60'd0, exp_mv[k]});
        check($sformatf("rand%0d_held_c%0d", t, k), {60'd0, obs_held[k]}, {60'd0, exp_held[k]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_input_conditioner.md
FROG_INPUT_CONDITIONER -- requirements
Module: frog_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 50_000_000: cycles in HELD before the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 25_000_000: cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have parameter REPEAT_EN, default 1: 0 disables auto-repeat.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port btn_n, input, 4 bits: raw asynchronous buttons, active-low; [3]=up, [2]=down, [1]=left, [0]=right.
REQ-008 The block SHALL have port mv_up, output, 1 bit: one-cycle move-up pulse.
REQ-009 The block SHALL have port mv_down, output, 1 bit: one-cycle move-down pulse.
REQ-010 The block SHALL have port mv_left, output, 1 bit: one-cycle move-left pulse.
REQ-011 The block SHALL have port mv_right, output, 1 bit: one-cycle move-right pulse.
REQ-012 The block SHALL have port held, output, 4 bits: debounced pressed level, active-high, same bit order as btn_n.

Function
REQ-013 Each btn_n bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each button SHALL have an independent FSM with states IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-015 IDLE -> PRESS_CHK on a synchronized low sample; the debounce counter clears on entry.
REQ-016 PRESS_CHK -> HELD once DEBOUNCE_CYCLES consecutive low samples are seen; any high sample returns to IDLE.
REQ-017 HELD -> RELEASE_CHK on a high sample; RELEASE_CHK -> IDLE after DEBOUNCE_CYCLES consecutive high samples; any low sample returns to HELD without a pulse and without clearing the repeat counter.
REQ-018 Latency: a raw low first sampled at edge t and held stable SHALL produce a press event in cycle t+2+DEBOUNCE_CYCLES.
REQ-019 held[i] SHALL be 1 in HELD and RELEASE_CHK, and 0 otherwise.
REQ-020 With REPEAT_EN=1, a repeat event SHALL fire HOLD_CYCLES cycles after entering HELD, then every REPEAT_CYCLES cycles while held[i]=1.
REQ-021 Press and repeat events SHALL be exactly one cycle wide; no event SHALL fire on release.
REQ-022 Vertical axis arbitration: if up and down events coincide, mv_up SHALL fire and the down event SHALL be dropped.
REQ-023 Horizontal axis arbitration: if right and left events coincide, mv_right SHALL fire and the left event SHALL be dropped.
REQ-024 One vertical and one horizontal pulse MAY assert in the same cycle.
REQ-025 mv_* outputs SHALL be registered.
REQ-026 Counters SHALL be sized to $clog2 of the largest parameter plus 1, and SHALL saturate, never wrap.
REQ-027 A button held low through reset release SHALL produce a press event per REQ-018, counted from the first post-reset edge.

Reset
REQ-028 While reset=1: all FSMs IDLE, all counters 0, synchronizer flops 1 (released), mv_*=0, held=0.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.

Structure
REQ-030 Package frog_pkg SHALL hold the FSM state encoding and the button index constants BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0.
REQ-031 The block SHALL use one sub-module, btn_debounce_fsm (one button: synchronizer, FSM, counters, held and event outputs), instantiated 4 times; arbitration and output registers SHALL live in the top level.

Verification
REQ-032 Bench parameters SHALL be DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
REQ-033 Clean press: btn_n[3] low from edge 10 -> mv_up high only in cycle 16; held[3]=1 from cycle 16.
REQ-034 Bounce: btn_n[0] toggles low/high every 2 cycles for 20 cycles, then stays high -> no mv_right pulse; held[0] stays 0.
REQ-035 Auto-repeat: btn_n[1] held low for 40 cycles from edge 0 -> mv_left pulses in cycles 6, 16, 21, 26, 31, 36, 41; none after release.
REQ-036 Simultaneous press: btn_n[3] and btn_n[2] low at the same edge -> mv_up pulses and mv_down never pulses.
REQ-037 Cross-axis press: btn_n[3] and btn_n[1] low together -> mv_up and mv_left pulse in the same cycle.
REQ-038 Reset mid-debounce: reset asserted 2 cycles after btn_n[0] goes low -> no pulse; after reset deasserts with the button still low, mv_right pulses 6 cycles later.
